// File: rtl/input_interface_buffered_if.sv
// Host write bus and memory write bus for input_interface_buffered.
// The host drives through modport master; the block implements modport slave.
interface input_interface_buffered_if #(
  parameter int INST_W  = 15,
  parameter int INST_AW = 8,
  parameter int DATA_W  = 128,
  parameter int DATA_AW = 8
);
  logic               in_we_inst_mem;
  logic [INST_W-1:0]  in_data_inst_mem;
  logic [INST_AW-1:0] in_address_inst_mem;
  logic               inst_ready;
  logic               out_we_inst_mem;
  logic [INST_W-1:0]  out_data_inst_mem;
  logic [INST_AW-1:0] out_address_inst_mem;

  logic               in_we_data_mem;
  logic [DATA_W-1:0]  in_data_data_mem;
  logic [DATA_AW-1:0] in_address_data_mem;
  logic               data_ready;
  logic               out_we_data_mem;
  logic [DATA_W-1:0]  out_data_data_mem;
  logic [DATA_AW-1:0] out_address_data_mem;

  modport master (
    output in_we_inst_mem, in_data_inst_mem, in_address_inst_mem,
    output in_we_data_mem, in_data_data_mem, in_address_data_mem,
    input  inst_ready, out_we_inst_mem, out_data_inst_mem, out_address_inst_mem,
    input  data_ready, out_we_data_mem, out_data_data_mem, out_address_data_mem
  );

  modport slave (
    input  in_we_inst_mem, in_data_inst_mem, in_address_inst_mem,
    input  in_we_data_mem, in_data_data_mem, in_address_data_mem,
    output inst_ready, out_we_inst_mem, out_data_inst_mem, out_address_inst_mem,
    output data_ready, out_we_data_mem, out_data_data_mem, out_address_data_mem
  );
endinterface

// File: rtl/input_interface_buffered.sv
// GPU front-end input interface: buffered instruction/data memory writes plus a
// conversion/draw/clear sequencer. Define INPUT_IF_PERF_CNT_EN for draw/stall counters.
module input_interface_buffered #(
  parameter int INST_W     = 15,
  parameter int INST_AW    = 8,
  parameter int DATA_W     = 128,
  parameter int DATA_AW    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input_interface_buffered_if.slave bus,
  input  logic enable_in,
  output logic enable_out,
  input  logic in_start_serial_parallel_conv,
  output logic out_start_serial_parallel_conv,
  input  logic in_finsh_serial_parallel_conv,
  input  logic in_start_writting,
  output logic out_start_trin_line,
  input  logic in_triangle_finsh,
  input  logic in_line_drawin_finsh,
  output logic out_draw_done,
  input  logic in_start_clear,
  output logic out_start_clear,
  output logic busy,
  output logic overflow
`ifdef INPUT_IF_PERF_CNT_EN
  ,
  output logic [15:0] draw_count,
  output logic [15:0] stall_cycles
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IEW = INST_AW + INST_W;
  localparam int DEW = DATA_AW + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_WAIT_CONV, S_DRAW, S_WAIT_DRAW, S_DONE, S_CLEAR
  } state_t;

  logic [IEW-1:0]     r_inst_fifo [FIFO_DEPTH];
  logic [PW-1:0]      r_inst_wptr, r_inst_rptr;
  logic [CW-1:0]      r_inst_cnt;
  logic               r_inst_we;
  logic [INST_W-1:0]  r_inst_data;
  logic [INST_AW-1:0] r_inst_addr;
  logic [DEW-1:0]     r_data_fifo [FIFO_DEPTH];
  logic [PW-1:0]      r_data_wptr, r_data_rptr;
  logic [CW-1:0]      r_data_cnt;
  logic               r_data_we;
  logic [DATA_W-1:0]  r_data_data;
  logic [DATA_AW-1:0] r_data_addr;
  logic               r_overflow, r_enable_out;
  state_t             r_state;
  logic               r_start_conv, r_start_draw, r_draw_done, r_start_clear;

  logic w_inst_full, w_inst_push, w_inst_pop;
  logic w_data_full, w_data_push, w_data_pop;

  // Full/empty are judged on registered counts only, so a same-cycle pop never frees a slot.
  assign w_inst_full = (r_inst_cnt == CW'(FIFO_DEPTH));
  assign w_inst_push = bus.in_we_inst_mem && !w_inst_full;
  assign w_inst_pop  = (r_inst_cnt != '0) && enable_in;
  assign w_data_full = (r_data_cnt == CW'(FIFO_DEPTH));
  assign w_data_push = bus.in_we_data_mem && !w_data_full;
  assign w_data_pop  = (r_data_cnt != '0) && enable_in;

  always_ff @(posedge clk) begin
    if (w_inst_push) r_inst_fifo[r_inst_wptr] <= {bus.in_address_inst_mem, bus.in_data_inst_mem};
    if (w_data_push) r_data_fifo[r_data_wptr] <= {bus.in_address_data_mem, bus.in_data_data_mem};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_wptr <= '0; r_inst_rptr <= '0; r_inst_cnt <= '0;
      r_inst_we <= 1'b0; r_inst_data <= '0; r_inst_addr <= '0;
      r_data_wptr <= '0; r_data_rptr <= '0; r_data_cnt <= '0;
      r_data_we <= 1'b0; r_data_data <= '0; r_data_addr <= '0;
      r_overflow <= 1'b0; r_enable_out <= 1'b0;
    end else begin
      r_enable_out <= enable_in;
      if ((bus.in_we_inst_mem && w_inst_full) || (bus.in_we_data_mem && w_data_full))
        r_overflow <= 1'b1;
      if (w_inst_push) r_inst_wptr <= r_inst_wptr + 1'b1;
      if (w_inst_pop)  r_inst_rptr <= r_inst_rptr + 1'b1;
      if (w_inst_push && !w_inst_pop)      r_inst_cnt <= r_inst_cnt + 1'b1;
      else if (!w_inst_push && w_inst_pop) r_inst_cnt <= r_inst_cnt - 1'b1;
      r_inst_we <= w_inst_pop;
      if (w_inst_pop) {r_inst_addr, r_inst_data} <= r_inst_fifo[r_inst_rptr];
      if (w_data_push) r_data_wptr <= r_data_wptr + 1'b1;
      if (w_data_pop)  r_data_rptr <= r_data_rptr + 1'b1;
      if (w_data_push && !w_data_pop)      r_data_cnt <= r_data_cnt + 1'b1;
      else if (!w_data_push && w_data_pop) r_data_cnt <= r_data_cnt - 1'b1;
      r_data_we <= w_data_pop;
      if (w_data_pop) {r_data_addr, r_data_data} <= r_data_fifo[r_data_rptr];
    end
  end

  // Pulse outputs are set on entry to their state, so each is high exactly while in it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_start_conv <= 1'b0; r_start_draw <= 1'b0;
      r_draw_done <= 1'b0; r_start_clear <= 1'b0;
    end else begin
      r_start_conv <= 1'b0; r_start_draw <= 1'b0;
      r_draw_done <= 1'b0; r_start_clear <= 1'b0;
      case (r_state)
        S_IDLE:
          if (in_start_serial_parallel_conv) begin
            r_state <= S_CONV; r_start_conv <= 1'b1;
          end else if (in_start_clear) begin
            r_state <= S_CLEAR; r_start_clear <= 1'b1;
          end
        S_CONV: r_state <= S_WAIT_CONV;
        S_WAIT_CONV:
          if (in_finsh_serial_parallel_conv && in_start_writting) begin
            r_state <= S_DRAW; r_start_draw <= 1'b1;
          end
        S_DRAW: r_state <= S_WAIT_DRAW;
        S_WAIT_DRAW:
          if (in_triangle_finsh || in_line_drawin_finsh) begin
            r_state <= S_DONE; r_draw_done <= 1'b1;
          end
        S_DONE:  r_state <= S_IDLE;
        S_CLEAR: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef INPUT_IF_PERF_CNT_EN
  logic [15:0] r_draw_count, r_stall_cycles;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_draw_count <= '0; r_stall_cycles <= '0;
    end else begin
      if (r_state == S_DONE) r_draw_count <= r_draw_count + 1'b1;
      if (((r_inst_cnt != '0) || (r_data_cnt != '0)) && !enable_in && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end
  assign draw_count   = r_draw_count;
  assign stall_cycles = r_stall_cycles;
`endif

  assign bus.inst_ready           = !w_inst_full;
  assign bus.out_we_inst_mem      = r_inst_we;
  assign bus.out_data_inst_mem    = r_inst_data;
  assign bus.out_address_inst_mem = r_inst_addr;
  assign bus.data_ready           = !w_data_full;
  assign bus.out_we_data_mem      = r_data_we;
  assign bus.out_data_data_mem    = r_data_data;
  assign bus.out_address_data_mem = r_data_addr;
  assign enable_out               = r_enable_out;
  assign out_start_serial_parallel_conv = r_start_conv;
  assign out_start_trin_line      = r_start_draw;
  assign out_draw_done            = r_draw_done;
  assign out_start_clear          = r_start_clear;
  assign busy                     = (r_state != S_IDLE);
  assign overflow                 = r_overflow;
endmodule

// File: tb/tb_input_interface_buffered.sv
// Directed bench for input_interface_buffered with a scoreboard on both memory write streams.
module tb_input_interface_buffered;
  localparam int INST_W = 15, INST_AW = 8, DATA_W = 128, DATA_AW = 8, FIFO_DEPTH = 4;
  typedef logic [INST_AW+INST_W-1:0] ie_t;
  typedef logic [DATA_AW+DATA_W-1:0] de_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable_in = 1'b0, enable_out;
  logic start_conv = 1'b0, o_conv, finsh_conv = 1'b0, start_writting = 1'b0, o_trin;
  logic tri_finsh = 1'b0, line_finsh = 1'b0, o_done, start_clear = 1'b0, o_clear;
  logic busy, overflow;

  int n_cmp = 0, n_err = 0;
  int n_inst_we = 0, n_data_we = 0;
  ie_t q_inst[$];
  de_t q_data[$];

  input_interface_buffered_if #(.INST_W(INST_W), .INST_AW(INST_AW), .DATA_W(DATA_W), .DATA_AW(DATA_AW)) bus ();

  input_interface_buffered #(.INST_W(INST_W), .INST_AW(INST_AW), .DATA_W(DATA_W),
                             .DATA_AW(DATA_AW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .enable_in(enable_in), .enable_out(enable_out),
    .in_start_serial_parallel_conv(start_conv), .out_start_serial_parallel_conv(o_conv),
    .in_finsh_serial_parallel_conv(finsh_conv), .in_start_writting(start_writting),
    .out_start_trin_line(o_trin), .in_triangle_finsh(tri_finsh),
    .in_line_drawin_finsh(line_finsh), .out_draw_done(o_done),
    .in_start_clear(start_clear), .out_start_clear(o_clear),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every memory write strobe must match the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (bus.out_we_inst_mem === 1'b1) begin
      n_inst_we++;
      chk("inst_expected", 160'(q_inst.size() != 0), 160'd1);
      if (q_inst.size() != 0)
        chk("inst_order", 160'({bus.out_address_inst_mem, bus.out_data_inst_mem}), 160'(q_inst.pop_front()));
    end
    if (bus.out_we_data_mem === 1'b1) begin
      n_data_we++;
      chk("data_expected", 160'(q_data.size() != 0), 160'd1);
      if (q_data.size() != 0)
        chk("data_order", 160'({bus.out_address_data_mem, bus.out_data_data_mem}), 160'(q_data.pop_front()));
    end
  end

  initial begin
    int base;
    logic [DATA_W-1:0] dv;
    logic [INST_W-1:0] iv;
    bus.in_we_inst_mem = 1'b0; bus.in_data_inst_mem = '0; bus.in_address_inst_mem = '0;
    bus.in_we_data_mem = 1'b0; bus.in_data_data_mem = '0; bus.in_address_data_mem = '0;

    // Reset state
    repeat (3) step();
    chk("rst_inst_we", 160'(bus.out_we_inst_mem), 160'd0);
    chk("rst_data_we", 160'(bus.out_we_data_mem), 160'd0);
    chk("rst_inst_ready", 160'(bus.inst_ready), 160'd1);
    chk("rst_data_ready", 160'(bus.data_ready), 160'd1);
    chk("rst_busy", 160'(busy), 160'd0);
    chk("rst_overflow", 160'(overflow), 160'd0);
    chk("rst_enable_out", 160'(enable_out), 160'd0);
    chk("rst_pulses", 160'({o_conv, o_trin, o_done, o_clear}), 160'd0);
    rst = 1'b0;
    step();

    // Single instruction write: latency 2
    enable_in = 1'b1;
    bus.in_we_inst_mem = 1'b1; bus.in_address_inst_mem = 8'h05; bus.in_data_inst_mem = 15'h1234;
    q_inst.push_back({8'h05, 15'h1234});
    step();
    chk("t1_we_c1", 160'(bus.out_we_inst_mem), 160'd0);
    chk("t1_enable_out", 160'(enable_out), 160'd1);
    bus.in_we_inst_mem = 1'b0;
    step();
    chk("t1_we_c2", 160'(bus.out_we_inst_mem), 160'd1);
    chk("t1_addr", 160'(bus.out_address_inst_mem), 160'h05);
    chk("t1_data", 160'(bus.out_data_inst_mem), 160'h1234);
    chk("t1_ready", 160'(bus.inst_ready), 160'd1);
    step();
    chk("t1_we_c3", 160'(bus.out_we_inst_mem), 160'd0);
    chk("t1_data_hold", 160'(bus.out_data_inst_mem), 160'h1234);

    // Data FIFO overflow with drain disabled
    enable_in = 1'b0;
    step();
    base = n_data_we;
    for (int i = 0; i < 5; i++) begin
      dv = {$urandom, $urandom, $urandom, $urandom};
      bus.in_we_data_mem = 1'b1; bus.in_address_data_mem = 8'(8'h40 + i); bus.in_data_data_mem = dv;
      if (i < FIFO_DEPTH) q_data.push_back({8'(8'h40 + i), dv});
      step();
      chk("t2_data_ready", 160'(bus.data_ready), 160'(i < FIFO_DEPTH - 1));
    end
    bus.in_we_data_mem = 1'b0;
    chk("t2_overflow", 160'(overflow), 160'd1);
    step();
    chk("t2_held", 160'(n_data_we - base), 160'd0);
    enable_in = 1'b1;
    repeat (8) step();
    chk("t2_pulses", 160'(n_data_we - base), 160'd4);
    chk("t2_drained", 160'(q_data.size()), 160'd0);
    chk("t2_ready_back", 160'(bus.data_ready), 160'd1);
    chk("t2_overflow_sticky", 160'(overflow), 160'd1);

    // Alternating instruction/data writes every cycle
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) begin
        iv = 15'($urandom);
        bus.in_we_inst_mem = 1'b1; bus.in_we_data_mem = 1'b0;
        bus.in_address_inst_mem = 8'(i); bus.in_data_inst_mem = iv;
        q_inst.push_back({8'(i), iv});
      end else begin
        dv = {$urandom, $urandom, $urandom, $urandom};
        bus.in_we_inst_mem = 1'b0; bus.in_we_data_mem = 1'b1;
        bus.in_address_data_mem = 8'(8'h80 + i); bus.in_data_data_mem = dv;
        q_data.push_back({8'(8'h80 + i), dv});
      end
      step();
    end
    bus.in_we_inst_mem = 1'b0; bus.in_we_data_mem = 1'b0;
    repeat (4) step();
    chk("t3_inst_drained", 160'(q_inst.size()), 160'd0);
    chk("t3_data_drained", 160'(q_data.size()), 160'd0);

    // Conversion then gated draw
    start_conv = 1'b1;
    step();
    chk("t4_conv_pulse", 160'(o_conv), 160'd1);
    chk("t4_busy", 160'(busy), 160'd1);
    start_conv = 1'b0;
    step();
    chk("t4_conv_once", 160'(o_conv), 160'd0);
    finsh_conv = 1'b1; start_writting = 1'b0;
    base = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (o_trin === 1'b1) base++;
    end
    chk("t4_no_early_draw", 160'(base), 160'd0);
    start_writting = 1'b1;
    step();
    chk("t4_draw_pulse", 160'(o_trin), 160'd1);
    step();
    chk("t4_draw_once", 160'(o_trin), 160'd0);
    chk("t4_no_done_yet", 160'(o_done), 160'd0);
    line_finsh = 1'b1;
    step();
    chk("t4_done_pulse", 160'(o_done), 160'd1);
    line_finsh = 1'b0; finsh_conv = 1'b0; start_writting = 1'b0;
    step();
    chk("t4_done_once", 160'(o_done), 160'd0);
    chk("t4_idle", 160'(busy), 160'd0);

    // Conversion has priority over clear
    start_conv = 1'b1; start_clear = 1'b1;
    step();
    chk("t5_conv_wins", 160'(o_conv), 160'd1);
    chk("t5_no_clear", 160'(o_clear), 160'd0);
    start_conv = 1'b0; start_clear = 1'b0;
    finsh_conv = 1'b1; start_writting = 1'b1;
    step();
    step();
    chk("t5_draw", 160'(o_trin), 160'd1);
    finsh_conv = 1'b0; start_writting = 1'b0;
    start_clear = 1'b1;
    base = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_clear === 1'b1) base++;
    end
    chk("t5_clear_ignored", 160'(base), 160'd0);
    chk("t5_wait_draw_busy", 160'(busy), 160'd1);
    start_clear = 1'b0;

    // Reset during WAIT_DRAW with pending instruction entries
    enable_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_we_inst_mem = 1'b1; bus.in_address_inst_mem = 8'(8'hC0 + i); bus.in_data_inst_mem = 15'(i + 1);
      step();
    end
    bus.in_we_inst_mem = 1'b0;
    rst = 1'b1;
    step();
    chk("t6_busy", 160'(busy), 160'd0);
    chk("t6_we", 160'({bus.out_we_inst_mem, bus.out_we_data_mem}), 160'd0);
    chk("t6_outs", 160'({bus.out_address_inst_mem, bus.out_data_inst_mem}), 160'd0);
    chk("t6_pulses", 160'({o_conv, o_trin, o_done, o_clear}), 160'd0);
    chk("t6_overflow", 160'(overflow), 160'd0);
    rst = 1'b0;
    enable_in = 1'b1;
    base = n_inst_we;
    repeat (5) step();
    chk("t6_fifo_empty", 160'(n_inst_we - base), 160'd0);
    chk("t6_still_idle", 160'(busy), 160'd0);

    // Plain clear sequence
    start_clear = 1'b1;
    step();
    chk("t7_clear_pulse", 160'(o_clear), 160'd1);
    start_clear = 1'b0;
    step();
    chk("t7_clear_once", 160'(o_clear), 160'd0);
    chk("t7_idle", 160'(busy), 160'd0);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/input_interface_buffered.md
Name: input_interface_buffered

Overview:
- Parametrised successor to the GPU front-end input interface.
- Accepts host writes to instruction and data memory through independent, depth-configurable write FIFOs, and drains them to the memories when enabled.
- Replaces the combinational start/finish wiring with a registered control sequencer that orders conversion, draw, and clear phases.
- Sits between the host/test interface and the instruction memory, data memory, serial-parallel converter, triangle/line engines and clear unit.

Parameters:
- INST_W, 15, instruction word width
- INST_AW, 8, instruction memory address width
- DATA_W, 128, data memory word width
- DATA_AW, 8, data memory address width
- FIFO_DEPTH, 4, entries per write FIFO; power of two, minimum 2

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_we_inst_mem  in  1  host instruction write request
- in_data_inst_mem  in  INST_W  instruction word
- in_address_inst_mem  in  INST_AW  instruction address
- inst_ready  out  1  instruction FIFO not full
- out_we_inst_mem  out  1  instruction memory write strobe
- out_data_inst_mem  out  INST_W  instruction memory data
- out_address_inst_mem  out  INST_AW  instruction memory address
- in_we_data_mem, in_data_data_mem, in_address_data_mem, data_ready, out_we_data_mem, out_data_data_mem, out_address_data_mem: same as the instruction set, with DATA_W / DATA_AW widths
- enable_in  in  1  drain enable for both FIFOs
- enable_out  out  1  enable_in registered by one cycle
- in_start_serial_parallel_conv  in  1  host start-conversion request
- out_start_serial_parallel_conv  out  1  one-cycle conversion start pulse
- in_finsh_serial_parallel_conv  in  1  converter done (level)
- in_start_writting  in  1  host permits drawing (level)
- out_start_trin_line  out  1  one-cycle draw start pulse
- in_triangle_finsh, in_line_drawin_finsh  in  1  engine done (level or pulse)
- out_draw_done  out  1  one-cycle pulse when a draw completes
- in_start_clear  in  1  host clear request
- out_start_clear  out  1  one-cycle clear start pulse
- busy  out  1  sequencer not in IDLE
- overflow  out  1  sticky: write dropped because its FIFO was full

Behaviour:
- Reset: all outputs 0, both FIFOs empty, sequencer in IDLE, overflow cleared. Reset mid-operation discards all FIFO contents and any in-flight sequence.
- FIFO push:
  - Push when in_we high and the FIFO is not full, judged on the registered count.
  - A push while full is dropped and sets overflow, even if a pop occurs in the same cycle.
  - ready = !full.
- FIFO pop:
  - Pop when the FIFO is not empty and enable_in is high.
  - out_we, out_addr and out_data are registered; out_we is high for exactly one cycle per entry.
  - out_data/out_address hold their last value when out_we is 0.
  - Latency: in_we in cycle c reaches out_we in cycle c+2 (FIFO empty, enable high).
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; entries drain strictly in order.
  - With enable_in low, no pop occurs and the FIFO holds its contents.
- The instruction and data FIFOs are fully independent of each other.
- Sequencer states: IDLE, CONV, WAIT_CONV, DRAW, WAIT_DRAW, DONE, CLEAR.
  - IDLE: start_conv has priority over start_clear. start_conv -> CONV; otherwise start_clear -> CLEAR.
  - CONV: out_start_serial_parallel_conv=1 for one cycle, then -> WAIT_CONV.
  - WAIT_CONV: when finsh_conv && start_writting -> DRAW.
  - DRAW: out_start_trin_line=1 for one cycle, then -> WAIT_DRAW.
  - WAIT_DRAW: triangle_finsh || line_drawin_finsh -> DONE.
  - DONE: out_draw_done=1 for one cycle, then -> IDLE.
  - CLEAR: out_start_clear=1 for one cycle, then -> IDLE.
  - Requests arriving outside IDLE are ignored; the host must re-assert them.
  - Finish inputs are ignored outside their wait states.
- busy = (state != IDLE).
- Start requests are sampled as levels. A request held high through DONE restarts a new sequence on the next IDLE cycle.

Optional Feature:
- Macro: INPUT_IF_PERF_CNT_EN.
- When defined, adds outputs:
  - draw_count[15:0]: increments in DONE, wraps at 0xFFFF.
  - stall_cycles[15:0]: increments on every cycle either FIFO is non-empty with enable_in low; saturates at 0xFFFF.
  - Both counters clear on rst.
- When undefined, these ports and counters are absent and the rest of the block behaves identically.

Test Plan:
- Reset, then one instruction write (addr 0x05, data 0x1234), enable=1 -> out_we_inst_mem high in cycle c+2 with 0x05/0x1234; inst_ready stays 1.
- enable=0; five data writes with FIFO_DEPTH=4 -> data_ready low after the 4th write, 5th dropped, overflow=1; then enable=1 -> exactly 4 out_we pulses in write order.
- Alternate instruction and data writes every cycle with enable=1 -> each stream is delivered in order, with no cross-FIFO interference.
- start_conv pulse; finsh_conv=1 but start_writting=0 for 10 cycles; then start_writting=1 -> out_start_trin_line one pulse only after start_writting; line_finsh=1 -> out_draw_done one pulse; busy returns to 0.
- start_conv and start_clear asserted in the same IDLE cycle -> conversion starts, clear is ignored; start_clear during WAIT_DRAW -> no out_start_clear.
- rst asserted during WAIT_DRAW with 3 FIFO entries pending -> next cycle state is IDLE, FIFOs empty, no out_we, all outputs 0.
